// File: rtl/counter_pkg.sv
// Shared definitions for the counter stage and its downstream wrap capture.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/wrap_accum.sv
// Wrap accumulator: clears and latches the effective target on load, counts events, flags the completing event.
// Latency: done is combinational from inc and the registered accumulator; count updates on the next edge.
// Backpressure: none; the caller gates inc.
module wrap_accum #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WRAP_W-1:0] target,
  input  logic              inc,
  output logic [WRAP_W-1:0] acc_nxt,
  output logic              done
);

  logic [WRAP_W-1:0] wrap_acc;
  logic [WRAP_W-1:0] target_q;
  logic [WRAP_W:0]   nxt_w;

  // One extra bit so the terminal compare cannot alias on a full-scale target.
  assign nxt_w   = {1'b0, wrap_acc} + 1'b1;
  assign acc_nxt = nxt_w[WRAP_W-1:0];
  assign done    = inc && (nxt_w == {1'b0, target_q});

  // Load clears the count and latches the target (zero means one); inc counts until the terminal event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_acc <= '0;
      target_q <= '0;
    end else if (load) begin
      wrap_acc <= '0;
      target_q <= (target == '0) ? {{(WRAP_W-1){1'b0}}, 1'b1} : target;
    end else if (inc && !done) begin
      wrap_acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/wrap_capture.sv
// Arms on request, counts upstream counter wraps to a target, then snapshots the wrap total and live count.
// Latency: snapshot valid one cycle after the completing overflow; idle one cycle after the handshake.
// Backpressure: snapshot held stable while snap_ready is low; overflows seen meanwhile set the sticky missed flag.
module wrap_capture
  import counter_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              ovf_in,
  input  logic              arm,
  input  logic              abort,
  input  logic [WRAP_W-1:0] target,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic [WRAP_W-1:0] snap_wraps,
  output logic [CNT_W-1:0]  snap_count,
  output logic              busy,
  output logic              missed
);

  state_t            state;
  state_t            state_nxt;
  logic              acc_load;
  logic              acc_inc;
  logic              acc_done;
  logic              snap_load;
  logic [WRAP_W-1:0] acc_nxt;

  // Accumulator controls depend only on registered state and inputs, keeping the done path loop-free.
  assign acc_load = (state == S_IDLE) && arm;
  assign acc_inc  = (state == S_ARMED) && ovf_in;

  wrap_accum #(
    .WRAP_W (WRAP_W)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .load    (acc_load),
    .target  (target),
    .inc     (acc_inc),
    .acc_nxt (acc_nxt),
    .done    (acc_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort beats a completing overflow, arm/abort are ignored while holding.
  always_comb begin
    state_nxt = state;
    snap_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (acc_done) begin
          snap_load = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (snap_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      snap_valid <= (state_nxt == S_HOLD);
      busy       <= (state_nxt != S_IDLE);
    end
  end

  // Snapshot captured on the completing event and kept after the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_wraps <= '0;
      snap_count <= '0;
    end else if (snap_load) begin
      snap_wraps <= acc_nxt;
      snap_count <= cnt_in;
    end
  end

  // Missed flag: set by any overflow while holding, cleared only by an accepted arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      missed <= 1'b0;
    end else if (acc_load) begin
      missed <= 1'b0;
    end else if ((state == S_HOLD) && ovf_in) begin
      missed <= 1'b1;
    end
  end

endmodule
